// File: rtl/morph_ctrl_pkg.sv
// Shared types and sizing helpers for the morphology frame sequencer.
package morph_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } state_e;

  // Counter width for n distinct values, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Pad beats needed to push the last row through the 3x3 line buffer.
  function automatic int flush_len(input int w);
    return w + 1;
  endfunction

  localparam int DEF_W     = 640;
  localparam int DEF_H     = 480;
  localparam int DEF_COL_W = cnt_width(DEF_W);
  localparam int DEF_ROW_W = cnt_width(DEF_H);

endpackage

// File: rtl/morph_pos_counter.sv
// Row/column raster counter with synchronous clear, enable and end-of-frame flag.
module morph_pos_counter
  import morph_ctrl_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int H     = DEF_H,
  parameter int COL_W = DEF_COL_W,
  parameter int ROW_W = DEF_ROW_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [ROW_W-1:0] row_o,
  output logic [COL_W-1:0] col_o,
  output logic             last_o
);

  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             row_last, col_last;

  assign row_last = (row_q == ROW_W'(H - 1));
  assign col_last = (col_q == COL_W'(W - 1));

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr_i) begin
      row_d = '0;
      col_d = '0;
    end else if (en_i) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = row_last & col_last;

endmodule

// File: rtl/morph_frame_ctrl.sv
// Frame sequencer feeding the 3x3 morphology datapath: forwards one frame,
// pads W+1 beats to drain the line buffer and tags each valid window centre.
module morph_frame_ctrl
  import morph_ctrl_pkg::*;
#(
  parameter int                        IMG_WIDTH_DATA = 24,
  parameter int                        IMG_WIDTH_LINE = DEF_W,
  parameter int                        IMG_HEIGHT     = DEF_H,
  parameter logic [IMG_WIDTH_DATA-1:0] PAD_VALUE      = '0
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [IMG_WIDTH_DATA-1:0]            src_data,
  input  logic                                 src_valid,
  output logic                                 src_ready,
  output logic [IMG_WIDTH_DATA-1:0]            win_data,
  output logic                                 win_en,
  output logic                                 ctr_valid,
  output logic [cnt_width(IMG_HEIGHT)-1:0]     ctr_row,
  output logic [cnt_width(IMG_WIDTH_LINE)-1:0] ctr_col,
  output logic                                 border,
  output logic                                 busy,
  output logic                                 done
);

  localparam int ROW_W     = cnt_width(IMG_HEIGHT);
  localparam int COL_W     = cnt_width(IMG_WIDTH_LINE);
  localparam int FLUSH_LEN = flush_len(IMG_WIDTH_LINE);
  localparam int PUSH_W    = cnt_width(FLUSH_LEN + 1);

  state_e                    state_q;
  logic                      src_ready_q, busy_q, done_q;
  logic                      win_en_q, ctr_valid_q;
  logic [IMG_WIDTH_DATA-1:0] win_data_q;
  logic [ROW_W-1:0]          ctr_row_q, in_row, pos_row;
  logic [COL_W-1:0]          ctr_col_q, in_col, pos_col;
  logic [PUSH_W-1:0]         push_cnt_q;
  logic                      accept, flush_push, push, push_sat, centre_en;
  logic                      clr, in_last, ctr_last, flush_end;

  assign accept     = src_valid & src_ready_q;
  assign flush_push = (state_q == ST_FLUSH);
  assign push       = accept | flush_push;
  assign push_sat   = (push_cnt_q == PUSH_W'(FLUSH_LEN));
  assign centre_en  = push & push_sat;
  assign clr        = (state_q == ST_IDLE) & start;

  // The input counter keeps running over the pad beats, so index W (row 1,
  // col 0) marks the final pad; the centre counter reaches its last centre on
  // that same beat.
  assign flush_end = ctr_last && (in_row == ROW_W'(1)) && (in_col == '0);

  morph_pos_counter #(
    .W(IMG_WIDTH_LINE), .H(IMG_HEIGHT), .COL_W(COL_W), .ROW_W(ROW_W)
  ) u_in_pos (
    .clk(clk), .rst_n(rst_n), .clr_i(clr), .en_i(push),
    .row_o(in_row), .col_o(in_col), .last_o(in_last)
  );

  morph_pos_counter #(
    .W(IMG_WIDTH_LINE), .H(IMG_HEIGHT), .COL_W(COL_W), .ROW_W(ROW_W)
  ) u_ctr_pos (
    .clk(clk), .rst_n(rst_n), .clr_i(clr), .en_i(centre_en),
    .row_o(pos_row), .col_o(pos_col), .last_o(ctr_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      src_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      win_en_q    <= 1'b0;
      win_data_q  <= '0;
      ctr_valid_q <= 1'b0;
      ctr_row_q   <= '0;
      ctr_col_q   <= '0;
      push_cnt_q  <= '0;
    end else begin
      win_en_q    <= push;
      ctr_valid_q <= centre_en;
      done_q      <= 1'b0;
      if (push) win_data_q <= accept ? src_data : PAD_VALUE;
      if (centre_en) begin
        ctr_row_q <= pos_row;
        ctr_col_q <= pos_col;
      end
      if (clr) push_cnt_q <= '0;
      else if (push && !push_sat) push_cnt_q <= push_cnt_q + PUSH_W'(1);

      case (state_q)
        ST_IDLE: if (start) begin
          state_q     <= ST_RUN;
          src_ready_q <= 1'b1;
          busy_q      <= 1'b1;
        end
        ST_RUN: if (accept && in_last) begin
          state_q     <= ST_FLUSH;
          src_ready_q <= 1'b0;
        end
        ST_FLUSH: if (flush_end) state_q <= ST_DONE;
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign src_ready = src_ready_q;
  assign win_en    = win_en_q;
  assign win_data  = win_data_q;
  assign ctr_valid = ctr_valid_q;
  assign ctr_row   = ctr_row_q;
  assign ctr_col   = ctr_col_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign border    = ctr_valid_q &&
                     ((ctr_row_q == '0) || (ctr_row_q == ROW_W'(IMG_HEIGHT - 1)) ||
                      (ctr_col_q == '0) || (ctr_col_q == COL_W'(IMG_WIDTH_LINE - 1)));

endmodule

// File: doc/morph_frame_ctrl.md
# morph_frame_ctrl

Frame sequencer that sits in front of the 3x3 binary morphology (etch/dilate) datapath and drives its `data_in`/`data_in_en` inputs. It accepts one frame of pixels from an upstream valid/ready source and forwards them one per accepted beat. It then injects padding pixels so the line buffer drains the last row. Alongside each forwarded beat it tags the 3x3 window centre with row/column position, a border flag and a centre-valid strobe.

## Interface
- `IMG_WIDTH_DATA`, 24: pixel width in bits.
- `IMG_WIDTH_LINE`, 640: pixels per line (W), at least 2.
- `IMG_HEIGHT`, 480: lines per frame (H), at least 2.
- `PAD_VALUE`, 0: pixel value injected during flush.
- `clk` in 1: pixel clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle pulse; begins a frame when idle.
- `src_data` in IMG_WIDTH_DATA: upstream pixel.
- `src_valid` in 1: upstream pixel valid.
- `src_ready` out 1: controller accepts a pixel this cycle.
- `win_data` out IMG_WIDTH_DATA: pixel to the datapath.
- `win_en` out 1: datapath enable; one pulse per pushed pixel.
- `ctr_valid` out 1: the current `win_en` beat completes a valid window centre.
- `ctr_row` out CLOG2(H): centre row.
- `ctr_col` out CLOG2(W): centre column.
- `border` out 1: the centre is on row 0, row H-1, column 0 or column W-1.
- `busy` out 1: frame in progress.
- `done` out 1: one-cycle pulse at end of frame.

## Operation
- States are IDLE, RUN, FLUSH and DONE.
- **IDLE**
  - `src_ready`=0.
  - `start`=1 moves to RUN and clears all counters.
  - `src_valid` is ignored.
- **RUN**
  - `src_ready`=1.
  - An accept is `src_valid & src_ready`. On each accept:
    - `win_data` is loaded with `src_data`.
    - `win_en` is set for one cycle.
    - The input counter advances. Column wraps W-1 to 0 and increments the row.
  - The accept of pixel (H-1, W-1) moves to FLUSH.
- **FLUSH**
  - `src_ready`=0.
  - Pushes exactly W+1 beats of `PAD_VALUE`, one per consecutive cycle, each with `win_en`=1.
  - After the last pad beat, moves to DONE.
- **DONE**
  - `done`=1 for one cycle.
  - Then returns to IDLE.
- **Centre tracking**
  - A push counter counts `win_en` beats per frame; it saturates at W+1.
  - `ctr_valid`=1 on every `win_en` beat whose 0-based beat index is at least W+1.
  - The centre counter advances on each `ctr_valid` beat, with the same wrap as the input counter.
  - A frame therefore has exactly W*H+W+1 `win_en` beats and exactly W*H `ctr_valid` beats.
  - `border` is combinational from the centre counter and is qualified by `ctr_valid`; it is 0 when `ctr_valid`=0.
- `busy`=1 in RUN, FLUSH and DONE.
- `start` while busy is ignored and has no side effects.
- Reset at any time, including mid-frame, forces IDLE immediately. All counters clear. The next `start` begins a clean frame.

## Timing
- Reset values: every output is 0, and `win_data`=0.
- Latency from accept to the `win_en`/`win_data` beat is 1 cycle (registered).
- `ctr_valid`, `ctr_row`, `ctr_col` and `border` are aligned with the `win_en` beat they tag. The datapath's own output register adds its fixed latency downstream; this block does not model it.
- Gaps in `src_valid` produce gaps in `win_en`; there is no bubble compensation.
- Flush beats are back-to-back.
- The first flush beat follows the last RUN beat with no gap: RUN→FLUSH is registered on the final accept.
- `done` is asserted the cycle after the last flush `win_en` beat.
- `start` may be asserted in the cycle after `done`, when the block is back in IDLE.
- `src_ready` is a registered function of state. It drops in the cycle after the final accept, so no extra pixel is taken.

## Structure
- Package `morph_ctrl_pkg` holds:
  - the state enum (IDLE, RUN, FLUSH, DONE);
  - localparams for the counter widths (CLOG2 of W, H and W+1);
  - the flush length W+1.
- One sub-module, `morph_pos_counter`, is a row/column counter with enable, clear and end-of-frame flag. It is instantiated twice: input position and centre position.

## Test plan
- **Reset:** hold `rst_n`=0 with `src_valid`=1 → all outputs 0, `src_ready`=0, no `win_en`.
- **Contiguous frame**, W=4, H=3, `src_valid` always 1, pixels 1..12:
  - 12 accepts, then 5 `PAD_VALUE` beats; 17 `win_en` total.
  - First `ctr_valid` on beat index 5 with `ctr_row`/`ctr_col`=(0,0); 12 `ctr_valid` total.
  - `done` 1 cycle after beat 17.
- **Gapped source**, same frame with `src_valid` toggling every cycle → `win_en` only on accepts; counts identical to the contiguous case; flush beats back-to-back.
- **Border check**, W=4, H=3 → `border`=1 on 10 of 12 centres and 0 only at (1,1) and (1,2).
- **Protocol misuse:**
  - `src_valid`=1 in IDLE → not accepted.
  - `start` pulsed mid-RUN → ignored; frame still ends after 12 accepts.
- **Reset mid-frame:** assert `rst_n`=0 after 7 accepts → outputs 0 immediately. A following `start` plus a full frame gives exactly the contiguous-case counts.
